// File: rtl/ifu_next_pc.sv
// Fetch-address generator: PC register, next-PC select, illegal-target trap, fetch counter.
// Optional MIPS branch delay slot enabled by defining IFU_DELAY_SLOT_EN.
module ifu_next_pc #(
  parameter logic [31:0] PC_RESET   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter int          IM_WORDS   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_value,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        exc_adel,
  output logic [31:0] fetch_count
);

  localparam logic [1:0]  SEL_SEQ  = 2'b00;
  localparam logic [1:0]  SEL_BR   = 2'b01;
  localparam logic [1:0]  SEL_J    = 2'b10;
  localparam logic [31:0] PC_LIMIT = PC_RESET + 32'(4 * IM_WORDS);

  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        exc_adel_q, exc_adel_d;
  logic [31:0] target;
  logic        illegal;

`ifdef IFU_DELAY_SLOT_EN
  typedef enum logic {RUN, SLOT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pend_target_q, pend_target_d;
`endif

  assign pc_plus4    = pc_q + 32'd4;
  assign pc          = pc_q;
  assign exc_adel    = exc_adel_q;
  assign fetch_count = fetch_count_q;

  always_comb begin
    target = rs_value;
    case (npc_sel)
      SEL_BR:  target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
      SEL_J:   target = {pc_plus4[31:28], instr_index, 2'b00};
      default: target = rs_value;
    endcase
    // Sequential fetch running past the IM end is deliberately not trapped.
    illegal = (npc_sel != SEL_SEQ) &&
              ((target[1:0] != 2'b00) || (target < PC_RESET) || (target >= PC_LIMIT));
  end

  always_comb begin
    pc_d          = pc_q;
    exc_adel_d    = 1'b0;
    fetch_count_d = fetch_count_q;
`ifdef IFU_DELAY_SLOT_EN
    state_d       = state_q;
    pend_target_d = pend_target_q;
`endif
    if (!stall) begin
      fetch_count_d = fetch_count_q + 32'd1;
`ifdef IFU_DELAY_SLOT_EN
      // The slot instruction's own transfer request is ignored entirely.
      if (state_q == SLOT) begin
        pc_d    = pend_target_q;
        state_d = RUN;
      end else if (illegal) begin
        pc_d          = EXC_VECTOR;
        exc_adel_d    = 1'b1;
        pend_target_d = '0;
        state_d       = RUN;
      end else if (npc_sel != SEL_SEQ) begin
        pc_d          = pc_plus4;
        pend_target_d = target;
        state_d       = SLOT;
      end else begin
        pc_d = pc_plus4;
      end
`else
      if (illegal) begin
        pc_d       = EXC_VECTOR;
        exc_adel_d = 1'b1;
      end else if (npc_sel != SEL_SEQ) begin
        pc_d = target;
      end else begin
        pc_d = pc_plus4;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= PC_RESET;
      exc_adel_q    <= 1'b0;
      fetch_count_q <= '0;
`ifdef IFU_DELAY_SLOT_EN
      state_q       <= RUN;
      pend_target_q <= '0;
`endif
    end else begin
      pc_q          <= pc_d;
      exc_adel_q    <= exc_adel_d;
      fetch_count_q <= fetch_count_d;
`ifdef IFU_DELAY_SLOT_EN
      state_q       <= state_d;
      pend_target_q <= pend_target_d;
`endif
    end
  end

endmodule

// File: tb/tb_ifu_next_pc.sv
// Directed bench for ifu_next_pc; delay-slot sequence runs when IFU_DELAY_SLOT_EN is defined.
module tb_ifu_next_pc;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_sel;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] rs_value;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        exc_adel;
  logic [31:0] fetch_count;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_fc = 0;

  ifu_next_pc dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_sel(npc_sel), .imm16(imm16),
    .instr_index(instr_index), .rs_value(rs_value), .pc(pc), .pc_plus4(pc_plus4),
    .exc_adel(exc_adel), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Present one request, let one rising edge consume it, then sample 1ns later.
  task automatic step(input logic st, input logic [1:0] sel, input logic [15:0] imm,
                      input logic [25:0] idx, input logic [31:0] rs);
    stall = st; npc_sel = sel; imm16 = imm; instr_index = idx; rs_value = rs;
    @(posedge clk); #1;
    if (!st) exp_fc = exp_fc + 32'd1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; npc_sel = 2'b00; imm16 = '0; instr_index = '0; rs_value = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_pc", pc, 32'h3000);
    chk("rst_exc", {31'd0, exc_adel}, 32'd0);
    chk("rst_fc", fetch_count, 32'd0);
    chk("rst_pc4", pc_plus4, 32'h3004);

`ifdef IFU_DELAY_SLOT_EN
    step(0, 2'b01, 16'h0004, 26'h0, 32'h0);
    chk("ds_slot_pc", pc, 32'h3004);
    step(1, 2'b10, 16'h0, 26'h0000C10, 32'h0);
    chk("ds_stall_pc", pc, 32'h3004);
    chk("ds_stall_fc", fetch_count, exp_fc);
    step(0, 2'b10, 16'h0, 26'h0000C10, 32'h0);
    chk("ds_redirect", pc, 32'h3014);
    chk("ds_exc0", {31'd0, exc_adel}, 32'd0);
    step(0, 2'b11, 16'h0, 26'h0, 32'h0000_3001);
    chk("ds_trap_pc", pc, 32'h4180);
    chk("ds_trap_exc", {31'd0, exc_adel}, 32'd1);
    step(0, 2'b11, 16'h0, 26'h0, 32'h0000_3100);
    chk("ds_jr_slot", pc, 32'h4184);
    step(0, 2'b11, 16'h0, 26'h0, 32'h0000_5000);
    chk("ds_jr_tgt", pc, 32'h3100);
    chk("ds_fc", fetch_count, exp_fc);
`else
    step(0, 2'b00, 16'h0, 26'h0, 32'h0);
    chk("seq1", pc, 32'h3004);
    step(0, 2'b00, 16'h0, 26'h0, 32'h0);
    chk("seq2", pc, 32'h3008);
    step(0, 2'b00, 16'h0, 26'h0, 32'h0);
    chk("seq3", pc, 32'h300C);
    chk("seq_fc", fetch_count, 32'd3);
    step(0, 2'b01, 16'hFFFE, 26'h0, 32'h0);
    chk("br_back", pc, 32'h3008);
    step(0, 2'b01, 16'hFFFF, 26'h0, 32'h0);
    chk("br_self", pc, 32'h3008);
    step(0, 2'b01, 16'h0002, 26'h0, 32'h0);
    chk("br_fwd", pc, 32'h3014);
    step(0, 2'b10, 16'h0, 26'h0000C10, 32'h0);
    chk("j_pc", pc, 32'h3040);
    step(0, 2'b11, 16'h0, 26'h0, 32'h0000_3001);
    chk("jr_mis_pc", pc, 32'h4180);
    chk("jr_mis_exc", {31'd0, exc_adel}, 32'd1);
    step(0, 2'b00, 16'h0, 26'h0, 32'h0);
    chk("seq_oor_pc", pc, 32'h4184);
    chk("exc_pulse", {31'd0, exc_adel}, 32'd0);
    step(0, 2'b11, 16'h0, 26'h0, 32'h0000_5000);
    chk("jr_oor_pc", pc, 32'h4180);
    chk("jr_oor_exc", {31'd0, exc_adel}, 32'd1);
    step(1, 2'b10, 16'h0, 26'h0000C10, 32'h0);
    chk("stall_exc", {31'd0, exc_adel}, 32'd0);
    chk("stall_pc1", pc, 32'h4180);
    step(1, 2'b10, 16'h0, 26'h0000C10, 32'h0);
    step(1, 2'b10, 16'h0, 26'h0000C10, 32'h0);
    chk("stall_pc3", pc, 32'h4180);
    chk("stall_fc", fetch_count, exp_fc);
    step(0, 2'b00, 16'h0, 26'h0, 32'h0);
    chk("unstall_pc", pc, 32'h4184);
    step(0, 2'b11, 16'h0, 26'h0, 32'h0000_3FFC);
    chk("jr_last", pc, 32'h3FFC);
    chk("jr_last_exc", {31'd0, exc_adel}, 32'd0);
    step(0, 2'b00, 16'h0, 26'h0, 32'h0);
    chk("seq_end_pc", pc, 32'h4000);
    chk("seq_end_exc", {31'd0, exc_adel}, 32'd0);
    step(0, 2'b11, 16'h0, 26'h0, 32'h0000_4000);
    chk("jr_hi_bnd", pc, 32'h4180);
    step(0, 2'b11, 16'h0, 26'h0, 32'h0000_3000);
    chk("jr_lo_bnd", pc, 32'h3000);
    chk("jr_lo_exc", {31'd0, exc_adel}, 32'd0);
    step(0, 2'b11, 16'h0, 26'h0, 32'h0000_2FFC);
    chk("jr_below", pc, 32'h4180);
    step(0, 2'b01, 16'h8000, 26'h0, 32'h0);
    chk("br_neg_oor", pc, 32'h4180);
    chk("run_fc", fetch_count, exp_fc);
    step(0, 2'b11, 16'h0, 26'h0, 32'h0000_3200);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_pc", pc, 32'h3000);
    chk("async_fc", fetch_count, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    exp_fc = 0;
    step(0, 2'b00, 16'h0, 26'h0, 32'h0);
    chk("post_rst_pc", pc, 32'h3004);
    chk("post_rst_fc", fetch_count, exp_fc);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
